sample_scheduler: RTL
=====================

SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

Interface
REQ-001 SHALL have parameter NUM_PINS, default 8: number of pin controllers on the shared bus (1..64).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: sample FIFO entries (power of two).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports host_en/host_rd/host_wr  input  1 each  host bus strobes.
REQ-006 SHALL have ports host_addr  input  21 and host_din  input  16  host address and write data.
REQ-007 SHALL have port host_dout  output  16  host read data: bus_din during host read cycles, else 0.
REQ-008 SHALL have ports bus_en/bus_rd/bus_wr  output  1 each, bus_addr  output  21, bus_dout  output  16  shared pin-controller bus.
REQ-009 SHALL have port bus_din  input  16  OR of all pin-controller read data; valid in the same cycle as the read strobe.
REQ-010 SHALL have ports scan_enable  input  1 and scan_mask  input  NUM_PINS  pins to poll.
REQ-011 SHALL have ports fifo_rd  input  1, fifo_data  output  16, fifo_empty  output  1, fifo_count  output  clog2(FIFO_DEPTH)+1.
REQ-012 SHALL have ports overflow  output  1 (sticky) and overflow_clr  input  1.

Function
REQ-013 Pin p register r SHALL be at address (p<<8)+r; SAMPLE_REG offset 7, SAMPLE_CNT offset 8.
REQ-014 Host SHALL have absolute priority: a cycle with host_en & (host_rd | host_wr) passes host strobes/addr/data to the bus unchanged; the scheduler holds its state and all registers that cycle.
REQ-015 In non-host cycles the scheduler drives bus_wr=0 and bus_rd=bus_en=1 only in SCAN_CNT/SCAN_REG; otherwise all bus outputs 0.
REQ-016 States: IDLE, SCAN_CNT, SCAN_REG (one-hot).
REQ-017 IDLE -> SCAN_CNT when scan_enable=1 and scan_mask!=0, with pointer at the first set mask bit at or after the current pointer (wrapping).
REQ-018 SCAN_CNT: read SAMPLE_CNT of pin ptr; if value != last_cnt[ptr] -> SCAN_REG, else advance pointer (1 cycle per unchanged pin).
REQ-019 SCAN_REG: read SAMPLE_REG, push entry, store the SCAN_CNT-captured count into last_cnt[ptr], advance pointer.
REQ-020 Advance SHALL select the next set mask bit after ptr, wrapping; the next state is SCAN_CNT if scan_enable=1 and mask!=0, else IDLE (current pin always completes).
REQ-021 Entry format SHALL be {sample bit[15], cnt[6:0] at [14:8], pin index[7:0]}.
REQ-022 Count comparison SHALL use inequality only, so 16-bit wrap 0xFFFF->0x0000 is detected as new.
REQ-023 Only one entry is recorded per visit even if the count advanced by more than 1.
REQ-024 FIFO SHALL be first-word-fall-through: fifo_data valid whenever fifo_empty=0; fifo_rd pops; fifo_rd while empty is ignored.
REQ-025 Push while full SHALL drop the entry and set overflow, unless fifo_rd is asserted that cycle (pop and push both occur, count unchanged).
REQ-026 overflow SHALL clear on overflow_clr; a simultaneous set wins.
REQ-027 scan_mask changes take effect at the next advance.

Reset
REQ-028 On reset: state IDLE, ptr 0, last_cnt all 0, FIFO empty (fifo_count 0, fifo_data 0), overflow 0, all bus outputs 0.
REQ-029 Reset mid-scan SHALL abort with no push.

Structure
REQ-030 Register offsets (7, 8), the address shift (8) and the entry field positions SHALL live in shared package mecobo_pkg.
REQ-031 FIFO SHALL be a separate sub-module sync_fifo (parameterised width/depth, FWFT, count output).

Verification
REQ-032 mask=0b0101, pin0 cnt 0->3, pin2 unchanged -> one entry {bit, 7'd3, 8'd0}; pin2 costs one cycle.
REQ-033 Host read of addr 0x0207 during SCAN_REG -> host_dout=bus_din; scheduler stalls one cycle, then pushes correctly.
REQ-034 Pin1 count 0xFFFF then 0x0000 with last_cnt 0xFFFF -> entry pushed with cnt field 7'h00.
REQ-035 FIFO_DEPTH=16, 17 new samples with no fifo_rd -> fifo_count=16, overflow=1; overflow_clr -> 0; full push with fifo_rd -> count stays 16, overflow stays 0.
REQ-036 scan_enable dropped in SCAN_CNT with a changed count -> SCAN_REG completes the push, then IDLE; reset mid-SCAN_REG -> fifo_empty=1, no entry.

Source files
------------

// File: rtl/mecobo_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mecobo_pkg : shared pin-controller bus map and sample entry format |
// | Revision   : 1.0                                                  |
// +------------------------------------------------------------------+
package mecobo_pkg;

  localparam int c_ADDR_W    = 21;
  localparam int c_DATA_W    = 16;
  localparam int c_PIN_SHIFT = 8;

  localparam logic [7:0] c_SAMPLE_REG_OFS = 8'd7;
  localparam logic [7:0] c_SAMPLE_CNT_OFS = 8'd8;

  localparam int c_ENTRY_SAMPLE_BIT = 15;
  localparam int c_ENTRY_CNT_LSB    = 8;
  localparam int c_ENTRY_CNT_W      = 7;
  localparam int c_ENTRY_PIN_LSB    = 0;
  localparam int c_ENTRY_PIN_W      = 8;

  // The pin level is reported in bit 0 of SAMPLE_REG.
  localparam int c_SAMPLE_SRC_BIT = 0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'b001,
    S_SCAN_CNT = 3'b010,
    S_SCAN_REG = 3'b100
  } sched_state_e;

  function automatic logic [c_ADDR_W-1:0] reg_addr(input logic [7:0] pin,
                                                   input logic [7:0] ofs);
    return (c_ADDR_W'(pin) << c_PIN_SHIFT) + c_ADDR_W'(ofs);
  endfunction

  function automatic logic [c_DATA_W-1:0] make_entry(input logic sample,
                                                     input logic [c_ENTRY_CNT_W-1:0] cnt,
                                                     input logic [c_ENTRY_PIN_W-1:0] pin);
    logic [c_DATA_W-1:0] e;
    e = '0;
    e[c_ENTRY_SAMPLE_BIT]                 = sample;
    e[c_ENTRY_CNT_LSB +: c_ENTRY_CNT_W]   = cnt;
    e[c_ENTRY_PIN_LSB +: c_ENTRY_PIN_W]   = pin;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_fifo : first-word-fall-through synchronous FIFO with count   |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_AW-1:0]  wr_q, rd_q;
  logic [c_AW:0]    count_q;
  logic             w_do_push, w_do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (c_AW + 1)'(DEPTH));
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_q];

  // A full FIFO still accepts a push when the same cycle pops.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (w_do_push) wr_q <= wr_q + c_AW'(1);
      if (w_do_pop)  rd_q <= rd_q + c_AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + (c_AW + 1)'(1);
        2'b01:   count_q <= count_q - (c_AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sample_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sample_scheduler : polls pin SAMPLE_CNT/REG, queues new samples   |
// | Revision         : 1.0                                           |
// +------------------------------------------------------------------+
module sample_scheduler
  import mecobo_pkg::*;
#(
  parameter int NUM_PINS   = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          host_en,
  input  logic                          host_rd,
  input  logic                          host_wr,
  input  logic [20:0]                   host_addr,
  input  logic [15:0]                   host_din,
  output logic [15:0]                   host_dout,
  output logic                          bus_en,
  output logic                          bus_rd,
  output logic                          bus_wr,
  output logic [20:0]                   bus_addr,
  output logic [15:0]                   bus_dout,
  input  logic [15:0]                   bus_din,
  input  logic                          scan_enable,
  input  logic [NUM_PINS-1:0]           scan_mask,
  input  logic                          fifo_rd,
  output logic [15:0]                   fifo_data,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr
);

  localparam int c_PTR_W = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1;
  localparam logic [c_PTR_W-1:0] c_LAST_PIN = c_PTR_W'(NUM_PINS - 1);

  sched_state_e       state_q;
  logic [c_PTR_W-1:0] ptr_q;
  logic [15:0]        cnt_q;
  logic [15:0]        last_cnt_q [NUM_PINS];
  logic               overflow_q;

  logic               w_host, w_mask_any, w_go, w_push, w_full;
  logic [c_PTR_W-1:0] w_start, ptr_d;
  logic [15:0]        w_entry;

  // First set mask bit at or after start, wrapping; keeps dflt when mask is empty.
  function automatic logic [c_PTR_W-1:0] first_set(input logic [NUM_PINS-1:0] mask,
                                                   input logic [c_PTR_W-1:0]  start,
                                                   input logic [c_PTR_W-1:0]  dflt);
    logic [c_PTR_W-1:0]  r;
    logic [NUM_PINS-1:0] sh;
    logic                f;
    int                  j;
    r = dflt;
    f = 1'b0;
    for (int i = 0; i < NUM_PINS; i++) begin
      j = int'(start) + i;
      if (j >= NUM_PINS) j = j - NUM_PINS;
      sh = mask >> j;
      if (!f && sh[0]) begin
        f = 1'b1;
        r = c_PTR_W'(j);
      end
    end
    return r;
  endfunction

  assign w_host     = host_en & (host_rd | host_wr);
  assign w_mask_any = |scan_mask;
  assign w_go       = scan_enable & w_mask_any;
  assign w_start    = (state_q == S_IDLE) ? ptr_q :
                      (ptr_q == c_LAST_PIN) ? '0 : ptr_q + c_PTR_W'(1);
  assign ptr_d      = first_set(scan_mask, w_start, ptr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < NUM_PINS; i++) last_cnt_q[i] <= '0;
    end else if (!w_host) begin
      case (state_q)
        S_IDLE: begin
          if (w_go) begin
            ptr_q   <= ptr_d;
            state_q <= S_SCAN_CNT;
          end
        end
        S_SCAN_CNT: begin
          if (bus_din != last_cnt_q[ptr_q]) begin
            cnt_q   <= bus_din;
            state_q <= S_SCAN_REG;
          end else begin
            if (w_mask_any) ptr_q <= ptr_d;
            state_q <= w_go ? S_SCAN_CNT : S_IDLE;
          end
        end
        S_SCAN_REG: begin
          last_cnt_q[ptr_q] <= cnt_q;
          if (w_mask_any) ptr_q <= ptr_d;
          state_q <= w_go ? S_SCAN_CNT : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_en   = 1'b0;
    bus_rd   = 1'b0;
    bus_wr   = 1'b0;
    bus_addr = '0;
    bus_dout = '0;
    if (w_host) begin
      bus_en   = host_en;
      bus_rd   = host_rd;
      bus_wr   = host_wr;
      bus_addr = host_addr;
      bus_dout = host_din;
    end else if (state_q == S_SCAN_CNT) begin
      bus_en   = 1'b1;
      bus_rd   = 1'b1;
      bus_addr = reg_addr(8'(ptr_q), c_SAMPLE_CNT_OFS);
    end else if (state_q == S_SCAN_REG) begin
      bus_en   = 1'b1;
      bus_rd   = 1'b1;
      bus_addr = reg_addr(8'(ptr_q), c_SAMPLE_REG_OFS);
    end
  end

  assign host_dout = (host_en & host_rd) ? bus_din : '0;

  assign w_push  = (state_q == S_SCAN_REG) & ~w_host & ~reset;
  assign w_entry = make_entry(bus_din[c_SAMPLE_SRC_BIT], cnt_q[c_ENTRY_CNT_W-1:0], 8'(ptr_q));

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (fifo_rd),
    .din   (w_entry),
    .dout  (fifo_data),
    .empty (fifo_empty),
    .full  (w_full),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset)                            overflow_q <= 1'b0;
    else if (w_push & w_full & ~fifo_rd)  overflow_q <= 1'b1;
    else if (overflow_clr)                overflow_q <= 1'b0;
  end

  assign overflow = overflow_q;

endmodule
`default_nettype wire
